// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage LSU issuing one variable-latency dmem access at a time.
// Define MIPS150_LSU_MISALIGN_TRAP_EN to add the misalign trap output.
module mem_stage_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [1:0]        mem_write,
  input  logic [2:0]        mask,
  input  logic              mem_to_reg,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              dmem_req,
  output logic [3:0]        dmem_we,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       load_data,
  output logic              load_valid
`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
  , output logic            misalign
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;
  logic done, store, load, memop, accept, mis;
  logic [2:0] mask_q;
  logic [1:0] off_q;
  logic [3:0] we_nx;
  logic [31:0] wd_nx, ld_ext;
  logic [15:0] ld_h;
  logic [7:0] ld_b;
  assign store = |mem_write;
  assign load = !store && mem_to_reg;
  assign memop = in_valid && (store || load);
  assign accept = state == IDLE && memop && !done;
  assign stall = state != IDLE || (memop && !done);
`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
  assign mis = ((mem_write == 2'b10 || (load && (mask == 3'b001 || mask == 3'b100))) && addr[0]) ||
               ((mem_write == 2'b11 || (load && mask != 3'b000 && mask != 3'b001 && mask != 3'b011 && mask != 3'b100)) && |addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    we_nx = mem_write == 2'b01 ? 4'b1000 >> addr[1:0] : mem_write == 2'b10 ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    wd_nx = mem_write == 2'b01 ? {4{store_data[7:0]}} : mem_write == 2'b10 ? {2{store_data[15:0]}} : store_data;
    // big-endian lanes: offset 0 is the most significant byte
    ld_b = off_q == 2'd0 ? dmem_rdata[31:24] : off_q == 2'd1 ? dmem_rdata[23:16] : off_q == 2'd2 ? dmem_rdata[15:8] : dmem_rdata[7:0];
    ld_h = off_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    ld_ext = mask_q == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
             mask_q == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
             mask_q == 3'b011 ? {24'b0, ld_b} :
             mask_q == 3'b100 ? {16'b0, ld_h} : dmem_rdata;
    state_nx = state == IDLE ? (accept && !mis ? REQ : IDLE) :
               state == REQ  ? (dmem_gnt ? (|dmem_we ? IDLE : WAIT) : REQ) :
               (dmem_rvalid ? IDLE : WAIT);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      load_data <= '0;
      load_valid <= 1'b0;
      mask_q <= '0;
      off_q <= '0;
    end else begin
      done <= 1'b0;
      load_valid <= 1'b0;
      if (accept && !mis) begin
        dmem_req <= 1'b1;
        dmem_addr <= addr[ADDR_W-1:2];
        dmem_we <= store ? we_nx : 4'b0000;
        dmem_wdata <= store ? wd_nx : '0;
        mask_q <= mask;
        off_q <= addr[1:0];
      end
      // a store request always has a nonzero byte enable, so we == 0 marks a load
      if (state == REQ && dmem_gnt) begin
        dmem_req <= 1'b0;
        done <= |dmem_we;
      end
      if (state == WAIT && dmem_rvalid) begin
        load_data <= ld_ext;
        load_valid <= 1'b1;
        done <= 1'b1;
      end
      if (accept && mis) begin
        done <= 1'b1;
        load_valid <= load;
        if (load) load_data <= '0;
      end
    end
  end
`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) misalign <= !rst && accept && mis;
`endif
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu against a byte-addressed memory model.
module tb_mem_stage_lsu;
  typedef struct {logic [3:0] we; logic [29:0] a; logic [31:0] wd;} req_t;
  typedef struct {logic [31:0] d; bit ld; bit mis;} ev_t;
`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 0, rst = 1, in_valid = 0, mem_to_reg = 0;
  logic [1:0] mem_write = 0;
  logic [2:0] mask = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic stall, dmem_req, dmem_gnt, dmem_rvalid, load_valid, misalign;
  logic [3:0] dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata, load_data;
  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_write(mem_write), .mask(mask),
    .mem_to_reg(mem_to_reg), .addr(addr), .store_data(store_data), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .load_valid(load_valid)
`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );
`ifndef MIPS150_LSU_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_req = 0;
  req_t exp_req[$];
  ev_t exp_ev[$];
  bit [31:0] wmem [int];
  bit [7:0] bmem [int];
  bit rand_lat = 0, stray_rv = 0;
  int gnt_dly = 0, rv_dly = 0;
  logic [31:0] last_ld, last_wd;
  logic [3:0] last_we;
  logic [29:0] last_a;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic bad(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask
  task automatic poke(input int w, input bit [31:0] v);
    wmem[w] = v;
    for (int b = 0; b < 4; b++) bmem[w*4+b] = v[31-8*b -: 8];
  endtask

  // memory model: grants after a delay, returns read data a delay after the grant
  initial begin
    bit seen = 0, rd_pend = 0;
    int g_cnt = 0, rd_cnt = 0, rd_a = 0;
    bit [31:0] t;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    forever begin
      @(posedge clk); #2;
      dmem_gnt = 0;
      dmem_rvalid = stray_rv;
      if (rst) begin
        seen = 0; rd_pend = 0;
      end else if (rd_pend) begin
        if (rd_cnt == 0) begin
          dmem_rvalid = 1; dmem_rdata = wmem.exists(rd_a) ? wmem[rd_a] : 0; rd_pend = 0;
        end else rd_cnt--;
      end else if (dmem_req) begin
        if (!seen) begin
          seen = 1; g_cnt = rand_lat ? int'($urandom_range(0, 3)) : gnt_dly;
        end
        if (g_cnt == 0) begin
          dmem_gnt = 1; seen = 0;
          if (dmem_we != 0) begin
            t = wmem.exists(int'(dmem_addr)) ? wmem[int'(dmem_addr)] : 0;
            for (int b = 0; b < 4; b++) if (dmem_we[3-b]) t[31-8*b -: 8] = dmem_wdata[31-8*b -: 8];
            wmem[int'(dmem_addr)] = t;
          end else begin
            rd_pend = 1; rd_a = int'(dmem_addr);
            rd_cnt = rand_lat ? int'($urandom_range(0, 3)) : rv_dly;
          end
        end else g_cnt--;
      end
    end
  end

  // monitor: pops scoreboard entries whenever the DUT presents a request or a result
  initial begin
    bit pv_req = 0, pv_gnt = 0;
    logic [66:0] pv = 0;
    req_t r;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) pv_req = 0;
      else begin
        if (pv_req && !pv_gnt) chk("req_hold", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, pv);
        if (dmem_req && dmem_gnt) begin
          n_req++;
          last_we = dmem_we; last_a = dmem_addr; last_wd = dmem_wdata;
          if (exp_req.size() == 0) bad("req_extra");
          else begin
            r = exp_req.pop_front();
            chk("req_we", dmem_we, r.we);
            chk("req_addr", dmem_addr, r.a);
            if (r.we != 0) chk("req_wdata", dmem_wdata, r.wd);
          end
        end
        if (load_valid || misalign) begin
          last_ld = load_data;
          if (exp_ev.size() == 0) bad("ev_extra");
          else begin
            e = exp_ev.pop_front();
            chk("ld_valid", load_valid, e.ld);
            if (e.ld) chk("ld_data", load_data, e.d);
            chk("misalign", misalign, e.mis);
          end
        end
        pv_req = dmem_req; pv_gnt = dmem_gnt; pv = {dmem_req, dmem_we, dmem_addr, dmem_wdata};
      end
    end
  end

  task automatic do_op(input logic v, input logic [1:0] mw, input logic [2:0] mk, input logic mtr,
                       input logic [31:0] a, input logic [31:0] sd, output int sc);
    bit st, ld, sg, ms;
    int n, s, w;
    logic [31:0] val, wd;
    logic [3:0] we;
    req_t r;
    ev_t e;
    st = mw != 0;
    ld = !st && mtr;
    n = st ? (mw == 1 ? 1 : mw == 2 ? 2 : 4) : (mk == 0 || mk == 3) ? 1 : (mk == 1 || mk == 4) ? 2 : 4;
    sg = mk == 0 || mk == 1;
    s = int'(a[1:0]) & ~(n - 1);
    w = int'(a >> 2);
    ms = TRAP && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 0));
    if (v && (st || ld)) begin
      if (ms) begin
        e.d = 0; e.ld = ld; e.mis = 1; exp_ev.push_back(e);
      end else if (st) begin
        we = 0; wd = 0;
        for (int b = 0; b < 4; b++) begin
          wd[31-8*b -: 8] = sd[8*(n-1-(b%n)) +: 8];
          if (b >= s && b < s + n) begin we[3-b] = 1; bmem[w*4+b] = wd[31-8*b -: 8]; end
        end
        r.we = we; r.a = a[31:2]; r.wd = wd; exp_req.push_back(r);
      end else begin
        val = 0;
        for (int k = 0; k < n; k++) val = (val << 8) | 32'(bmem.exists(w*4+s+k) ? bmem[w*4+s+k] : 8'd0);
        if (sg && n == 1) val = {{24{val[7]}}, val[7:0]};
        if (sg && n == 2) val = {{16{val[15]}}, val[15:0]};
        r.we = 0; r.a = a[31:2]; r.wd = 0; exp_req.push_back(r);
        e.d = val; e.ld = 1; e.mis = 0; exp_ev.push_back(e);
      end
    end
    in_valid = v; mem_write = mw; mask = mk; mem_to_reg = mtr; addr = a; store_data = sd;
    sc = 0;
    do begin
      @(negedge clk);
      if (stall) sc++;
    end while (stall && sc < 60);
    if (stall) bad("stall_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc, n0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, load_data, load_valid, misalign}, 0);
    @(posedge clk); #1 rst = 0;

    do_op(1, 2'b01, 3'b000, 0, 32'h1003, 32'h000000A5, sc);
    chk("sb_stall_cycles", sc, 2);
    chk("sb_we", last_we, 4'b0001);
    chk("sb_wdata", last_wd, 32'hA5A5A5A5);
    chk("sb_addr", last_a, 30'h400);

    poke(32'h2000 >> 2, 32'h12F45678);
    gnt_dly = 2;
    do_op(1, 2'b00, 3'b000, 1, 32'h2001, 0, sc);
    chk("lb_data", last_ld, 32'hFFFFFFF4);
    gnt_dly = 0;

    poke(32'h2000 >> 2, 32'h1234ABCD);
    do_op(1, 2'b00, 3'b100, 1, 32'h2002, 0, sc);
    chk("lhu_data", last_ld, 32'h0000ABCD);
    do_op(1, 2'b00, 3'b001, 1, 32'h2002, 0, sc);
    chk("lh_data", last_ld, 32'hFFFFABCD);

    n0 = n_req;
    do_op(1, 2'b11, 3'b000, 0, 32'h10, 32'hDEADBEEF, sc);
    do_op(1, 2'b00, 3'b010, 1, 32'h10, 0, sc);
    chk("b2b_nreq", n_req - n0, 2);
    chk("b2b_data", last_ld, 32'hDEADBEEF);

`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
    n0 = n_req;
    last_ld = 32'hFFFFFFFF;
    do_op(1, 2'b00, 3'b010, 1, 32'h3002, 0, sc);
    chk("mis_nreq", n_req - n0, 0);
    chk("mis_data", last_ld, 0);
`endif

    gnt_dly = 1000;
    in_valid = 1; mem_write = 0; mask = 3'b010; mem_to_reg = 1; addr = 32'h10;
    repeat (3) @(negedge clk);
    chk("rm_req_up", dmem_req, 1);
    @(posedge clk); #1 rst = 1; in_valid = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rm_req_clr", dmem_req, 0);
    chk("rm_stall", stall, 0);
    @(posedge clk); #1 stray_rv = 1;
    @(posedge clk); #1 stray_rv = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rm_no_lv", load_valid, 0);
    end
    @(posedge clk); #1;
    gnt_dly = 0;

    for (int i = 0; i < 16; i++) poke((32'h2000 >> 2) + i, $urandom);
    rand_lat = 1;
    repeat (250) begin
      logic [1:0] mw;
      mw = $urandom_range(0, 1) ? 2'(($urandom_range(1, 3))) : 2'b00;
      do_op($urandom_range(0, 5) != 0, mw, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            32'h2000 + $urandom_range(0, 63), $urandom, sc);
    end
    in_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("ev_queue_empty", exp_ev.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
